triple_fifo_uart_tx: RTL and testbench

Three independent write-side FIFOs are drained round-robin into a single UART serializer that drives one 8N1 line, `tx`. The block is the top level of the data-transmitter datapath. Upstream producers push words into the FIFOs at any time. Draining only occurs while `start` is high.

---
 rtl/dt_tx_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/triple_fifo_uart_tx.sv | 197 +++++++++++++++++++
 tb/tb_triple_fifo_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_tx_pkg.sv
// Shared types and defaults for the triple-FIFO UART transmitter.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit to each frame).
package dt_tx_pkg;

   localparam int unsigned NUM_CH           = 3;
   localparam int unsigned CH_W             = 2;
   localparam int unsigned DEF_DATA_W       = 8;
   localparam int unsigned DEF_FIFO_DEPTH   = 32;
   localparam int unsigned DEF_CLKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
`ifdef UART_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd5
   } tx_state_e;

   // Round-robin successor: 0 -> 1 -> 2 -> 0
   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
      return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered empty/full flags.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              empty_q;
   logic              full_q;
   logic [DATA_W-1:0] dout_q;
   logic              push;
   logic              pop;

   assign pop   = rd_en && !empty_q;
   assign push  = wr_en && (!full_q || pop);
   assign dout  = dout_q;
   assign empty = empty_q;
   assign full  = full_q;

   // Next occupancy from the accepted push/pop pair
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= din;
   end

   // Pointers, occupancy, flags and read data register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         dout_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            dout_q   <= mem[rd_ptr_q];
         end
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == CNT_W'(DEPTH));
      end
   end

endmodule

// File: rtl/triple_fifo_uart_tx.sv
// Three write-side FIFOs drained round-robin into one UART serializer.
// Optional feature macro: UART_PARITY_EN (inserts an even-parity bit before stop).
module triple_fifo_uart_tx
   import dt_tx_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              wr_en_fifo_1,
   input  logic [DATA_W-1:0] data_in_fifo_1,
   input  logic              wr_en_fifo_2,
   input  logic [DATA_W-1:0] data_in_fifo_2,
   input  logic              wr_en_fifo_3,
   input  logic [DATA_W-1:0] data_in_fifo_3,
   output logic              tx
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [NUM_CH-1:0] wr_en_v;
   logic [DATA_W-1:0] din_v  [NUM_CH];
   logic [DATA_W-1:0] dout_v [NUM_CH];
   logic [NUM_CH-1:0] rd_en_v;
   logic [NUM_CH-1:0] empty_v;
   logic [NUM_CH-1:0] fifo_full_unused;

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [CH_W-1:0]   sel_q, sel_d;
   logic              tx_q, tx_d;
`ifdef UART_PARITY_EN
   logic              par_q, par_d;
`endif

   logic              found;
   logic [CH_W-1:0]   pick_ch;
   logic              baud_done;

   assign wr_en_v   = {wr_en_fifo_3, wr_en_fifo_2, wr_en_fifo_1};
   assign din_v[0]  = data_in_fifo_1;
   assign din_v[1]  = data_in_fifo_2;
   assign din_v[2]  = data_in_fifo_3;
   assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign tx        = tx_q;

   genvar g;
   for (g = 0; g < NUM_CH; g++) begin : g_fifo
      sync_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .wr_en (wr_en_v[g]),
         .din   (din_v[g]),
         .rd_en (rd_en_v[g]),
         .dout  (dout_v[g]),
         .empty (empty_v[g]),
         .full  (fifo_full_unused[g])
      );
   end

   // Round-robin search: first non-empty channel starting at rr_q
   always_comb begin
      int unsigned c;
      found   = 1'b0;
      pick_ch = rr_q;
      c       = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         c = int'(rr_q) + i;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (!found && !empty_v[CH_W'(c)]) begin
            found   = 1'b1;
            pick_ch = CH_W'(c);
         end
      end
   end

   // FSM next-state, datapath next values and pop request
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      rr_d    = rr_q;
      sel_d   = sel_q;
      tx_d    = 1'b1;
      rd_en_v = '0;
`ifdef UART_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start && found) begin
               rd_en_v = NUM_CH'(1) << pick_ch;
               sel_d   = pick_ch;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            shreg_d = dout_v[sel_q];
`ifdef UART_PARITY_EN
            par_d   = ^dout_v[sel_q];
`endif
            baud_d  = '0;
            bit_d   = '0;
            state_d = ST_START;
         end
         ST_START: begin
            tx_d = 1'b0;
            if (baud_done) begin
               baud_d  = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            tx_d = shreg_q[0];
            if (baud_done) begin
               baud_d  = '0;
               shreg_d = shreg_q >> 1;
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  bit_d   = '0;
`ifdef UART_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            tx_d = par_q;
            if (baud_done) begin
               baud_d  = '0;
               state_d = ST_STOP;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
`endif
         ST_STOP: begin
            tx_d = 1'b1;
            if (baud_done) begin
               baud_d  = '0;
               rr_d    = next_ch(sel_q);
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset forces the line high at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         rr_q    <= '0;
         sel_q   <= '0;
         tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         rr_q    <= rr_d;
         sel_q   <= sel_d;
         tx_q    <= tx_d;
`ifdef UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_triple_fifo_uart_tx.sv
// Bench for triple_fifo_uart_tx: a line monitor decodes frames into a queue,
// expected frames are queued as stimulus is driven, then compared in order.
module tb_triple_fifo_uart_tx;

   localparam int unsigned DW  = 8;
   localparam int unsigned CPB = 16;
`ifdef UART_PARITY_EN
   localparam int unsigned FRAME_W = DW + 3;
`else
   localparam int unsigned FRAME_W = DW + 2;
`endif
   localparam int SETTLE = 400;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          wr1, wr2, wr3;
   logic [DW-1:0] d1, d2, d3;
   logic          tx;

   int checks   = 0;
   int failures = 0;

   logic [FRAME_W-1:0] exp_q [$];
   logic [FRAME_W-1:0] rx_q  [$];

   typedef struct {
      int            ch;
      logic [DW-1:0] data;
      logic          par;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   triple_fifo_uart_tx #(
      .DATA_W       (DW),
      .FIFO_DEPTH   (32),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .wr_en_fifo_1   (wr1),
      .data_in_fifo_1 (d1),
      .wr_en_fifo_2   (wr2),
      .data_in_fifo_2 (d2),
      .wr_en_fifo_3   (wr3),
      .data_in_fifo_3 (d3),
      .tx             (tx)
   );

   // Line monitor: samples each bit in its middle; frames cut by reset are dropped
   initial begin : monitor
      logic [FRAME_W-1:0] f;
      bit aborted;
      f = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            aborted = 1'b0;
            repeat (CPB / 2 - 1) begin
               @(negedge clk);
               if (rst_n !== 1'b1) aborted = 1'b1;
            end
            f[0] = tx;
            for (int b = 1; b < FRAME_W; b++) begin
               repeat (CPB) begin
                  @(negedge clk);
                  if (rst_n !== 1'b1) aborted = 1'b1;
               end
               f[b] = tx;
            end
            if (!aborted) rx_q.push_back(f);
         end
      end
   end

   function automatic logic [FRAME_W-1:0] make_frame(input logic [DW-1:0] d);
`ifdef UART_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {1'b1, d, 1'b0};
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic write_word(input int ch, input logic [DW-1:0] d);
      @(negedge clk);
      wr1 = (ch == 1); wr2 = (ch == 2); wr3 = (ch == 3);
      d1 = d; d2 = d; d3 = d;
      @(negedge clk);
      wr1 = 1'b0; wr2 = 1'b0; wr3 = 1'b0;
   endtask

   // Wait for the expected number of frames, let the line settle, then compare in order
   task automatic check_frames(input string name, input int budget);
      int n;
      logic [FRAME_W-1:0] e, r;
      n = 0;
      while (rx_q.size() < exp_q.size() && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (SETTLE) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rx_q.size() == 0) begin
            failures++;
            $display("FAIL %s: frame missing, got none, required %h", name, e);
         end else begin
            r = rx_q.pop_front();
            if (r !== e) begin
               failures++;
               $display("FAIL %s: frame got %h, required %h", name, r, e);
            end
         end
      end
      check({name, "_no_extra"}, 32'(rx_q.size()), 32'd0);
      rx_q.delete();
   endtask

   task automatic wait_tx_low(input string name, input int budget);
      int n;
      n = 0;
      while (tx !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(tx), 32'd0);
   endtask

   task automatic count_low(input string name, input int cycles);
      int lows;
      lows = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check(name, 32'(lows), 32'd0);
   endtask

   initial begin
      vecs[0] = '{ch: 1, data: 8'h01, par: 1'b1};
      vecs[1] = '{ch: 2, data: 8'hA5, par: 1'b0};
      vecs[2] = '{ch: 3, data: 8'h07, par: 1'b1};
      vecs[3] = '{ch: 1, data: 8'h03, par: 1'b0};
      vecs[4] = '{ch: 2, data: 8'hFF, par: 1'b0};
      vecs[5] = '{ch: 1, data: 8'h80, par: 1'b1};
      vecs[6] = '{ch: 3, data: 8'h5A, par: 1'b0};

      rst_n = 1'b0; start = 1'b0;
      wr1 = 1'b0; wr2 = 1'b0; wr3 = 1'b0;
      d1 = '0; d2 = '0; d3 = '0;

      // Reset then idle
      repeat (5) @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      rst_n = 1'b1;
      count_low("idle_high", 500);
      check("idle_no_frames", 32'(rx_q.size()), 32'd0);

      // First-frame latency on a single write of 0x01 to channel 1
      start = 1'b1;
      @(negedge clk);
      wr1 = 1'b1; d1 = 8'h01;
      exp_q.push_back(make_frame(8'h01));
      @(negedge clk);
      wr1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("latency_pre", 32'(tx), 32'd1);
      @(negedge clk);
      check("latency_fall", 32'(tx), 32'd0);
      check_frames("single_01", 400);

      // Table of single words with hand-computed parity
      for (int i = 0; i < 7; i++) begin
         write_word(vecs[i].ch, vecs[i].data);
`ifdef UART_PARITY_EN
         exp_q.push_back({1'b1, vecs[i].par, vecs[i].data, 1'b0});
`else
         exp_q.push_back({1'b1, vecs[i].data, 1'b0});
`endif
         check_frames($sformatf("vec%0d", i), 400);
      end

      // Round-robin: 30 simultaneous writes to all three channels
      for (int v = 1; v <= 30; v++) begin
         @(negedge clk);
         wr1 = 1'b1; wr2 = 1'b1; wr3 = 1'b1;
         d1 = DW'(v); d2 = DW'(v); d3 = DW'(v);
         for (int k = 0; k < 3; k++) exp_q.push_back(make_frame(DW'(v)));
      end
      @(negedge clk);
      wr1 = 1'b0; wr2 = 1'b0; wr3 = 1'b0;
      check_frames("round_robin", 20000);

      // Overflow: 40 writes into a 32-deep FIFO while draining is disabled
      start = 1'b0;
      for (int v = 0; v < 40; v++) begin
         @(negedge clk);
         wr2 = 1'b1; d2 = DW'(v);
         if (v < 32) exp_q.push_back(make_frame(DW'(v)));
      end
      @(negedge clk);
      wr2 = 1'b0;
      count_low("overflow_gated", 50);
      start = 1'b1;
      check_frames("overflow", 8000);

      // Start dropped mid-frame: the frame completes, nothing follows
      write_word(1, 8'hA1);
      write_word(1, 8'hA2);
      write_word(1, 8'hA3);
      exp_q.push_back(make_frame(8'hA1));
      wait_tx_low("gate_frame_start", 400);
      repeat (30) @(negedge clk);
      start = 1'b0;
      check_frames("gate_mid_frame", 600);
      count_low("gate_held_high", 300);

      // Reset mid-frame: line high at once, queued words discarded
      start = 1'b1;
      wait_tx_low("rst_frame_start", 400);
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_mid_tx", 32'(tx), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      count_low("post_reset_high", 500);
      check("post_reset_no_frames", 32'(rx_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
